// File: rtl/xalu_pkg.sv
// xalu_pkg: XALUOp encoding shared by the instruction decoder and the xalu mult/div unit
package xalu_pkg;
  localparam int XOP_W = 4;
  localparam logic [XOP_W-1:0] XOP_NONE  = 4'd0;
  localparam logic [XOP_W-1:0] XOP_MULT  = 4'd1;
  localparam logic [XOP_W-1:0] XOP_MULTU = 4'd2;
  localparam logic [XOP_W-1:0] XOP_MTHI  = 4'd3;
  localparam logic [XOP_W-1:0] XOP_MTLO  = 4'd4;
  localparam logic [XOP_W-1:0] XOP_MFHI  = 4'd5;
  localparam logic [XOP_W-1:0] XOP_MFLO  = 4'd6;
  localparam logic [XOP_W-1:0] XOP_DIV   = 4'd7;
  localparam logic [XOP_W-1:0] XOP_DIVU  = 4'd8;
  function automatic logic is_muldiv(input logic [XOP_W-1:0] op);
    return op == XOP_MULT || op == XOP_MULTU || op == XOP_DIV || op == XOP_DIVU;
  endfunction
endpackage

// File: rtl/xalu_if.sv
// xalu_if: EX-stage request (en, XALUOp, A, B) and xalu response (start, busy, HI, LO, XALUout)
interface xalu_if;
  import xalu_pkg::*;
  logic en;
  logic [XOP_W-1:0] XALUOp;
  logic [31:0] A, B;
  logic start, busy;
  logic [31:0] HI, LO, XALUout;
  modport master (output en, XALUOp, A, B, input start, busy, HI, LO, XALUout);
  modport slave (input en, XALUOp, A, B, output start, busy, HI, LO, XALUout);
endinterface

// File: rtl/xalu.sv
// xalu: multi-cycle mult/div unit owning HI/LO; ports clk, reset_n (sync active-low), bus (xalu_if.slave: en/XALUOp/A/B in, start/busy/HI/LO/XALUout out)
module xalu
  import xalu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset_n,
  xalu_if.slave bus
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] pend_q, pend_d, res, smul, umul;
  logic [31:0] da, db, q, r, sq, sr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, accept, start, done, is_mult, is_div;
  assign accept = bus.en & ~busy_q & reset_n;
  assign start = accept & is_muldiv(bus.XALUOp);
  assign done = busy_q & (cnt_q == CW'(1));
  assign is_mult = bus.XALUOp == XOP_MULT || bus.XALUOp == XOP_MULTU;
  assign is_div = bus.XALUOp == XOP_DIV;
  // signed divide goes through magnitudes so 0x80000000 / -1 never hits a native signed-overflow divide
  always_comb begin
    smul = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    umul = {32'd0, bus.A} * {32'd0, bus.B};
    da = is_div && bus.A[31] ? -bus.A : bus.A;
    db = is_div && bus.B[31] ? -bus.B : bus.B;
    q = db == 32'd0 ? 32'd0 : da / db;
    r = db == 32'd0 ? 32'd0 : da % db;
    sq = bus.A[31] ^ bus.B[31] ? -q : q;
    sr = bus.A[31] ? -r : r;
    res = bus.XALUOp == XOP_MULT ? smul :
          bus.XALUOp == XOP_MULTU ? umul :
          bus.B == 32'd0 ? {bus.A, 32'hFFFF_FFFF} :
          is_div ? {sr, sq} : {r, q};
  end
  always_comb begin
    pend_d = start ? res : pend_q;
    cnt_d = start ? (is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES)) : busy_q ? cnt_q - CW'(1) : cnt_q;
    busy_d = start | (busy_q & ~done);
    hi_d = done ? pend_q[63:32] : accept && bus.XALUOp == XOP_MTHI ? bus.A : hi_q;
    lo_d = done ? pend_q[31:0] : accept && bus.XALUOp == XOP_MTLO ? bus.A : lo_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
      pend_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  assign bus.start = start;
  assign bus.busy = busy_q;
  assign bus.HI = hi_q;
  assign bus.LO = lo_q;
  assign bus.XALUout = bus.XALUOp == XOP_MFHI ? hi_q : bus.XALUOp == XOP_MFLO ? lo_q : 32'd0;
endmodule

// File: tb/tb_xalu.sv
// tb_xalu: directed self-checking bench for xalu with hand-computed HI/LO/busy/start expectations
module tb_xalu;
  import xalu_pkg::*;
  logic clk = 1'b0;
  logic reset_n;
  int passed = 0;
  int total = 0;
  xalu_if bus ();
  xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic e, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.en = e;
    bus.XALUOp = op;
    bus.A = a;
    bus.B = b;
    #1;
  endtask
  task automatic muldiv(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] ehi, input logic [31:0] elo);
    drive(1'b1, op, a, b);
    chk({tag, " start"}, 32'(bus.start), 32'd1);
    step();
    drive(1'b0, XOP_NONE, 32'd0, 32'd0);
    chk({tag, " start drop"}, 32'(bus.start), 32'd0);
    for (int i = 0; i < n; i++) begin
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      step();
    end
    chk({tag, " busy end"}, 32'(bus.busy), 32'd0);
    chk({tag, " HI"}, bus.HI, ehi);
    chk({tag, " LO"}, bus.LO, elo);
  endtask
  initial begin
    reset_n = 1'b0;
    drive(1'b1, XOP_MULT, 32'd5, 32'd5);
    chk("start in reset", 32'(bus.start), 32'd0);
    step();
    step();
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst HI", bus.HI, 32'd0);
    chk("rst LO", bus.LO, 32'd0);
    reset_n = 1'b1;
    drive(1'b1, XOP_MFHI, 32'd0, 32'd0);
    chk("idle mfhi", bus.XALUout, 32'd0);
    chk("idle start", 32'(bus.start), 32'd0);
    step();
    muldiv("mult", XOP_MULT, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    muldiv("multu", XOP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE);
    muldiv("mult neg", XOP_MULT, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    muldiv("div", XOP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    muldiv("divu", XOP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    muldiv("div0", XOP_DIV, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
    muldiv("divu0", XOP_DIVU, 32'd9, 32'd0, 10, 32'd9, 32'hFFFF_FFFF);
    muldiv("div ovf", XOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    muldiv("div negb", XOP_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    drive(1'b1, XOP_DIV, 32'd100, 32'd7);
    chk("lock start", 32'(bus.start), 32'd1);
    step();
    drive(1'b1, XOP_MULT, 32'd1, 32'd1);
    chk("lock mult ignored", 32'(bus.start), 32'd0);
    step();
    drive(1'b0, XOP_NONE, 32'd0, 32'd0);
    step();
    drive(1'b1, XOP_MTLO, 32'h1234, 32'd0);
    chk("lock mtlo start", 32'(bus.start), 32'd0);
    step();
    chk("lock LO held", bus.LO, 32'hFFFF_FFFD);
    drive(1'b0, XOP_NONE, 32'd0, 32'd0);
    repeat (6) step();
    chk("lock busy c10", 32'(bus.busy), 32'd1);
    step();
    chk("lock busy end", 32'(bus.busy), 32'd0);
    chk("lock LO", bus.LO, 32'd14);
    chk("lock HI", bus.HI, 32'd2);
    drive(1'b1, XOP_MTLO, 32'h1234, 32'd0);
    step();
    chk("mtlo LO", bus.LO, 32'h1234);
    chk("mtlo HI", bus.HI, 32'd2);
    chk("mtlo busy", 32'(bus.busy), 32'd0);
    drive(1'b1, XOP_MULT, 32'd3, 32'd4);
    step();
    drive(1'b0, XOP_NONE, 32'd0, 32'd0);
    step();
    reset_n = 1'b0;
    step();
    chk("abort HI", bus.HI, 32'd0);
    chk("abort LO", bus.LO, 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    repeat (8) step();
    chk("no late LO", bus.LO, 32'd0);
    chk("no late HI", bus.HI, 32'd0);
    chk("no late busy", 32'(bus.busy), 32'd0);
    drive(1'b0, XOP_MULT, 32'd5, 32'd5);
    chk("bubble start", 32'(bus.start), 32'd0);
    step();
    chk("bubble busy", 32'(bus.busy), 32'd0);
    chk("bubble HI", bus.HI, 32'd0);
    drive(1'b1, XOP_MTHI, 32'hDEAD_BEEF, 32'd0);
    step();
    chk("mthi HI", bus.HI, 32'hDEAD_BEEF);
    chk("mthi LO", bus.LO, 32'd0);
    drive(1'b1, XOP_MFHI, 32'd0, 32'd0);
    chk("mfhi", bus.XALUout, 32'hDEAD_BEEF);
    drive(1'b1, XOP_MTLO, 32'hCAFE_0001, 32'd0);
    step();
    drive(1'b1, XOP_MFLO, 32'd0, 32'd0);
    chk("mflo", bus.XALUout, 32'hCAFE_0001);
    drive(1'b0, XOP_MTLO, 32'h5555_5555, 32'd0);
    step();
    chk("en0 mtlo LO", bus.LO, 32'hCAFE_0001);
    drive(1'b1, 4'd9, 32'd1, 32'd1);
    chk("unk start", 32'(bus.start), 32'd0);
    chk("unk out", bus.XALUout, 32'd0);
    step();
    chk("unk HI", bus.HI, 32'hDEAD_BEEF);
    chk("unk LO", bus.LO, 32'hCAFE_0001);
    chk("unk busy", 32'(bus.busy), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
